// File: rtl/xnor_popcount_acc.sv
`default_nettype none
// ============================================================================
//  Module   : xnor_popcount_acc
//  Purpose  : Final-layer BNN stage. XNORs each CHUNK_W-bit activation beat
//             against the weights of 10 output neurons and accumulates a
//             per-neuron popcount over N_BEATS beats. All 10 counts are
//             presented together with a one-cycle valid pulse.
//  Options  : XNOR_POPCOUNT_CLEAR_OUT_EN - when defined, popcount outputs
//             read zero in every cycle where valid_out is low.
//  Revision : 1.0 - initial release
// ============================================================================
module xnor_popcount_acc #(
   parameter int CHUNK_W = 16,
   parameter int N_BEATS = 25,
   parameter int CNT_W   = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic                    sof_in,
   input  logic [CHUNK_W-1:0]      act_in,
   input  logic [10*CHUNK_W-1:0]   weight_in,
   output logic [CNT_W-1:0]        popcount_out_1,
   output logic [CNT_W-1:0]        popcount_out_2,
   output logic [CNT_W-1:0]        popcount_out_3,
   output logic [CNT_W-1:0]        popcount_out_4,
   output logic [CNT_W-1:0]        popcount_out_5,
   output logic [CNT_W-1:0]        popcount_out_6,
   output logic [CNT_W-1:0]        popcount_out_7,
   output logic [CNT_W-1:0]        popcount_out_8,
   output logic [CNT_W-1:0]        popcount_out_9,
   output logic [CNT_W-1:0]        popcount_out_10,
   output logic                    valid_out,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int N_NEUR = 10;
   // Beat counter only ever holds 0..N_BEATS-1
   localparam int BEAT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]     acc_q [N_NEUR];
   logic [CNT_W-1:0]     acc_d [N_NEUR];
   logic [CNT_W-1:0]     pop_q [N_NEUR];
   logic [CNT_W-1:0]     pop_d [N_NEUR];
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   logic [CNT_W-1:0]     w_sum [N_NEUR];
   logic [CNT_W-1:0]     w_pop_vis [N_NEUR];
   logic                 w_take;
   logic                 w_last;

   for (genvar k = 0; k < N_NEUR; k++) begin : g_neuron
      logic [CHUNK_W-1:0] w_match;
      logic [CNT_W-1:0]   w_cnt;

      assign w_match = ~(act_in ^ weight_in[k*CHUNK_W +: CHUNK_W]);

      // Count bit positions where activation and neuron weight agree
      always_comb begin
         w_cnt = '0;
         for (int b = 0; b < CHUNK_W; b++) begin
            w_cnt = w_cnt + CNT_W'(w_match[b]);
         end
      end

      // A sof beat starts a fresh frame, so it never adds onto an old partial sum
      assign w_sum[k] = (sof_in ? '0 : acc_q[k]) + w_cnt;
   end

   // A beat is consumed if it opens a frame or continues one in progress;
   // a stray non-sof beat in IDLE is dropped.
   assign w_take = valid_in && (sof_in || (state_q == ACCUM));
   // A sof beat is beat 1 of its frame, so it is only the last one for 1-beat frames
   assign w_last = sof_in ? (N_BEATS == 1) : (beat_cnt_q == BEAT_W'(N_BEATS - 1));

   // Next-state: framing, accumulation and completion decisions
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      acc_d      = acc_q;
      pop_d      = pop_q;
      valid_d    = 1'b0;
      // Stray beat in IDLE or a resync sof in the middle of a frame
      err_d      = valid_in && (sof_in ? (state_q == ACCUM) : (state_q == IDLE));
      if (w_take) begin
         if (w_last) begin
            pop_d      = w_sum;
            valid_d    = 1'b1;
            acc_d      = '{default: '0};
            beat_cnt_d = '0;
            state_d    = IDLE;
         end else begin
            acc_d      = w_sum;
            beat_cnt_d = sof_in ? BEAT_W'(1) : (beat_cnt_q + BEAT_W'(1));
            state_d    = ACCUM;
         end
      end
   end

   // State, accumulators and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         for (int k = 0; k < N_NEUR; k++) begin
            acc_q[k] <= '0;
            pop_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         for (int k = 0; k < N_NEUR; k++) begin
            acc_q[k] <= acc_d[k];
            pop_q[k] <= pop_d[k];
         end
      end
   end

`ifdef XNOR_POPCOUNT_CLEAR_OUT_EN
   // Counts are only visible during the valid pulse, zero otherwise
   for (genvar k = 0; k < N_NEUR; k++) begin : g_out_clear
      assign w_pop_vis[k] = valid_q ? pop_q[k] : '0;
   end
`else
   // Counts hold the last completed frame until the next completion
   for (genvar k = 0; k < N_NEUR; k++) begin : g_out_hold
      assign w_pop_vis[k] = pop_q[k];
   end
`endif

   assign popcount_out_1  = w_pop_vis[0];
   assign popcount_out_2  = w_pop_vis[1];
   assign popcount_out_3  = w_pop_vis[2];
   assign popcount_out_4  = w_pop_vis[3];
   assign popcount_out_5  = w_pop_vis[4];
   assign popcount_out_6  = w_pop_vis[5];
   assign popcount_out_7  = w_pop_vis[6];
   assign popcount_out_8  = w_pop_vis[7];
   assign popcount_out_9  = w_pop_vis[8];
   assign popcount_out_10 = w_pop_vis[9];
   assign valid_out       = valid_q;
   assign frame_err       = err_q;
   assign busy            = (state_q == ACCUM);

endmodule
`default_nettype wire
